// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//
// Synthesizable sequencer that walks every input vector of a small combinational
// boolean datapath in ascending order. Each vector is held for SETTLE_CYCLES
// cycles of settling plus one sample cycle. The block builds the full truth
// table and can optionally count disagreements against a reference datapath.
//
// Optional feature: define TT_SWEEP_COMPARE_EN to compile the comparison logic.
// Without it, the mismatch outputs are constant 0 and f_ref_in is ignored.
//
// Ports:
//   clk                 sole clock, rising edge
//   rst_n               asynchronous active-low reset
//   start               sweep request, honoured only while idle
//   f_in                datapath output under test
//   f_ref_in            reference datapath output (compare build only)
//   vec_out             datapath input vector, MSB = A
//   busy                high from the cycle after start through the last sample
//   done                one-cycle completion pulse
//   table_out           bit k = f_in sampled while vec_out == k
//   mismatch_count      number of vectors where f_in != f_ref_in
//   first_mismatch      lowest mismatching vector index
//   first_mismatch_vld  first_mismatch holds a captured index
module truth_table_sweeper #(
    parameter int unsigned N_IN          = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  f_in,
    input  logic                  f_ref_in,
    output logic [N_IN-1:0]       vec_out,
    output logic                  busy,
    output logic                  done,
    output logic [(1<<N_IN)-1:0]  table_out,
    output logic [N_IN:0]         mismatch_count,
    output logic [N_IN-1:0]       first_mismatch,
    output logic                  first_mismatch_vld
);

    localparam int unsigned     NVEC        = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_VEC    = {N_IN{1'b1}};
    localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [NVEC-1:0]   table_q, table_d;

    // Shared with the compare logic: clear results on acceptance, compare on sample.
    logic sweep_start;
    logic sample_now;

    assign sweep_start = (state_q == StIdle) && start;
    assign sample_now  = (state_q == StSample);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            vec_q   <= '0;
            table_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            table_q <= table_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        table_d = table_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSettle;
                    cnt_d   = SETTLE_LOAD;
                    vec_d   = '0;
                    table_d = '0;
                end
            end
            StSettle: begin
                cnt_d = cnt_q - 8'd1;
                // Leaving on count 1 makes the settle phase exactly SETTLE_CYCLES long.
                if (cnt_q <= 8'd1) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                table_d[vec_q] = f_in;
                if (vec_q == LAST_VEC) begin
                    // Terminal vector ends the sweep; vec_out is held through done.
                    state_d = StDone;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = SETTLE_LOAD;
                    state_d = StSettle;
                end
            end
            StDone: begin
                state_d = StIdle;
                vec_d   = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign vec_out   = vec_q;
    assign table_out = table_q;
    assign busy      = (state_q == StSettle) || (state_q == StSample);
    assign done      = (state_q == StDone);

`ifdef TT_SWEEP_COMPARE_EN
    localparam logic [N_IN:0] MM_MAX = (N_IN + 1)'(NVEC);

    logic [N_IN:0]   mm_cnt_q, mm_cnt_d;
    logic [N_IN-1:0] mm_first_q, mm_first_d;
    logic            mm_vld_q, mm_vld_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_cnt_q   <= '0;
            mm_first_q <= '0;
            mm_vld_q   <= 1'b0;
        end else begin
            mm_cnt_q   <= mm_cnt_d;
            mm_first_q <= mm_first_d;
            mm_vld_q   <= mm_vld_d;
        end
    end

    always_comb begin
        mm_cnt_d   = mm_cnt_q;
        mm_first_d = mm_first_q;
        mm_vld_d   = mm_vld_q;
        if (sweep_start) begin
            mm_cnt_d   = '0;
            mm_first_d = '0;
            mm_vld_d   = 1'b0;
        end else if (sample_now && (f_in != f_ref_in)) begin
            if (mm_cnt_q != MM_MAX) begin
                mm_cnt_d = mm_cnt_q + 1'b1;
            end
            if (!mm_vld_q) begin
                mm_first_d = vec_q;
                mm_vld_d   = 1'b1;
            end
        end
    end

    assign mismatch_count     = mm_cnt_q;
    assign first_mismatch     = mm_first_q;
    assign first_mismatch_vld = mm_vld_q;
`else
    // Comparison not built: reference input is intentionally left unobserved.
    logic unused_cmp;
    assign unused_cmp = f_ref_in ^ sweep_start ^ sample_now;

    assign mismatch_count     = '0;
    assign first_mismatch     = '0;
    assign first_mismatch_vld = 1'b0;
`endif

endmodule
